eng_ingress: RTL
================

Name: eng_ingress

Overview:
- Command ingress stage directly upstream of eng_pipe inside eng.
- Accepts queue commands from the host side and screens out illegal opcodes.
- Buffers commands in a small FIFO and presents them one at a time to eng_pipe over a valid/ready handshake.
- Provides a drain-style flush for quiescing the engine.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- QID_W, 3, queue identifier width.
- DAT_W, 32, command payload width.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- cmd_vld_i  in  1  host command valid.
- cmd_op_i  in  2  opcode: 0 NOP, 1 PUSH, 2 POP, 3 reserved (illegal).
- cmd_qid_i  in  QID_W  target queue.
- cmd_dat_i  in  DAT_W  payload; meaningful for PUSH only.
- cmd_rdy_o  out  1  command accepted when cmd_vld_i and cmd_rdy_o are both high.
- pipe_vld_o  out  1  command valid to eng_pipe.
- pipe_op_o  out  2  opcode to eng_pipe.
- pipe_qid_o  out  QID_W  queue to eng_pipe.
- pipe_dat_o  out  DAT_W  payload to eng_pipe.
- pipe_rdy_i  in  1  eng_pipe ready.
- flush_i  in  1  flush request pulse.
- flush_done_o  out  1  one-cycle pulse when flush completes.
- err_illegal_o  out  1  one-cycle pulse, cycle after an illegal command is accepted.
- occ_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on arst_n.
- Reset values: state RUN; FIFO empty; occ_o 0; pipe_vld_o, flush_done_o and err_illegal_o all 0; cmd_rdy_o 1 after reset deasserts.
- Reset asserted mid-operation: all buffered entries are discarded immediately. No flush_done_o pulse is produced.
- cmd_rdy_o = (state == RUN) and not full. There is no same-cycle bypass when full; a pop in the same cycle does not raise cmd_rdy_o.
- Opcode screening on an accepted beat:
  - NOP: consumed, not enqueued.
  - Reserved opcode (3): consumed, not enqueued; err_illegal_o pulses the next cycle.
  - PUSH and POP: enqueued.
- FIFO is first-word-fall-through. The head entry drives the pipe_* outputs directly, with pipe_vld_o = not empty.
- Latency: a command accepted in cycle N is earliest on pipe_vld_o in cycle N+1.
- Pop occurs when pipe_vld_o and pipe_rdy_i are both high.
- pipe_* outputs are held stable while pipe_vld_o is high and pipe_rdy_i is low.
- Read and write pointers are $clog2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.
- occ_o = wptr - rptr.
- Simultaneous push and pop (not full, not empty): occupancy unchanged.
- Push into empty: occupancy becomes 1; pipe_vld_o rises the next cycle.
- State machine:
  - RUN: flush_i → FLUSH.
  - FLUSH: cmd_rdy_o = 0; buffered entries continue to drain normally and are not discarded. When empty → DONE.
  - DONE: flush_done_o = 1 for this cycle only → RUN.
- flush_i while in FLUSH or DONE is ignored.
- flush_i with the FIFO empty: RUN → FLUSH → DONE, so flush_done_o pulses 2 cycles after flush_i.
- flush_i in the same cycle as an accepted command: the command is enqueued, then drained by the flush.

Optional Feature:
- Macro: ENG_INGRESS_STATS_EN.
- Defined: adds outputs stat_acc_o (32 bits, accepted PUSH/POP count), stat_ill_o (16 bits, illegal command count) and stat_stall_o (32 bits, cycles with pipe_vld_o high and pipe_rdy_i low).
  - All counters saturate at their maximum value.
  - All counters reset to 0.
  - Counters are not cleared by flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (q_pkg):
  - opcode typedef and encodings: OP_NOP, OP_PUSH, OP_POP, OP_RSVD.
  - cmd_t packed struct {op, qid, dat}; the FIFO stores cmd_t.
  - ingress state enum {RUN, FLUSH, DONE}.
- Sub-module eng_ingress_fifo: parameterised FWFT FIFO holding cmd_t, with push, pop, full, empty and occupancy.
- eng_ingress contains the opcode screening, FSM and stats logic.

Test Plan:
- Reset, then PUSH qid=2 dat=0xA5A5_0001 in cycle 0 with pipe_rdy_i=1 → pipe_vld_o=1 in cycle 1 with op=1, qid=2, dat=0xA5A5_0001; occ_o returns to 0 in cycle 2.
- pipe_rdy_i=0, five back-to-back PUSHes (dat 1..5), DEPTH=4 → 4 accepted, cmd_rdy_o=0 with occ_o=4; raise pipe_rdy_i → outputs 1,2,3,4 in order, then 5 is accepted.
- cmd_op_i=3 accepted → err_illegal_o=1 the following cycle, occ_o stays 0; NOP → no enqueue and no error.
- 3 entries buffered with pipe_rdy_i=0, pulse flush_i → cmd_rdy_o=0; raise pipe_rdy_i → 3 pops, then flush_done_o pulses exactly once, then cmd_rdy_o=1.
- Steady full throughput with pipe_rdy_i=1 and cmd_vld_i=1 for 20 cycles → 1 command per cycle after the first-cycle latency; pointers wrap with no loss or duplication.
- Assert arst_n low with 2 entries buffered → pipe_vld_o=0 and occ_o=0 immediately; after release, the next PUSH appears at latency 1.

Source files
------------

// File: rtl/q_pkg.sv
// Shared types for the engine command path: opcodes, command record and ingress FSM states.
package q_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  localparam int QID_W_DEF = 3;
  localparam int DAT_W_DEF = 32;

  typedef struct packed {
    op_e                  op;
    logic [QID_W_DEF-1:0] qid;
    logic [DAT_W_DEF-1:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Only PUSH and POP carry work downstream; NOP and the reserved code are dropped.
  function automatic logic is_queued(op_e op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/eng_ingress_fifo.sv
// First-word-fall-through command FIFO; the head entry is always visible on rdata.
module eng_ingress_fifo
  import q_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra MSB so full and empty differ only in that bit.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign occ     = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/eng_ingress.sv
// Command ingress for eng: screens opcodes, buffers commands and drains on flush.
// Optional counters are built when ENG_INGRESS_STATS_EN is defined.
module eng_ingress
  import q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int QID_W = QID_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   cmd_vld_i,
  input  logic [1:0]             cmd_op_i,
  input  logic [QID_W-1:0]       cmd_qid_i,
  input  logic [DAT_W-1:0]       cmd_dat_i,
  output logic                   cmd_rdy_o,
  output logic                   pipe_vld_o,
  output logic [1:0]             pipe_op_o,
  output logic [QID_W-1:0]       pipe_qid_o,
  output logic [DAT_W-1:0]       pipe_dat_o,
  input  logic                   pipe_rdy_i,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  output logic                   err_illegal_o,
  output logic [$clog2(DEPTH):0] occ_o
`ifdef ENG_INGRESS_STATS_EN
  ,
  output logic [31:0]            stat_acc_o,
  output logic [15:0]            stat_ill_o,
  output logic [31:0]            stat_stall_o
`endif
);

  typedef struct packed {
    op_e              op;
    logic [QID_W-1:0] qid;
    logic [DAT_W-1:0] dat;
  } icmd_t;

  state_e state;
  state_e state_nxt;
  icmd_t  cmd_p0;
  icmd_t  head;
  logic   full;
  logic   empty;
  logic   accept_p0;
  logic   enq_p0;
  logic   ill_p0;
  logic   err_p1;
  logic   pop;

  // Stage 0: host beat acceptance and opcode screening.
  assign cmd_p0    = '{op: op_e'(cmd_op_i), qid: cmd_qid_i, dat: cmd_dat_i};
  assign cmd_rdy_o = (state == RUN) && !full;
  assign accept_p0 = cmd_vld_i && cmd_rdy_o;
  assign enq_p0    = accept_p0 && is_queued(cmd_p0.op);
  assign ill_p0    = accept_p0 && (cmd_p0.op == OP_RSVD);

  eng_ingress_fifo #(
    .DEPTH (DEPTH),
    .T     (icmd_t)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (enq_p0),
    .wdata  (cmd_p0),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .occ    (occ_o)
  );

  // Stage 1: FIFO head presented to eng_pipe.
  assign pipe_vld_o    = !empty;
  assign pipe_op_o     = head.op;
  assign pipe_qid_o    = head.qid;
  assign pipe_dat_o    = head.dat;
  assign pop           = pipe_vld_o && pipe_rdy_i;
  assign err_illegal_o = err_p1;
  assign flush_done_o  = (state == DONE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= RUN;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      err_p1 <= ill_p0;
    end
  end

  // Flush is a drain: buffered entries leave normally, only new intake is blocked.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_i) state_nxt = FLUSH;
      FLUSH:   if (empty)   state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef ENG_INGRESS_STATS_EN
  function automatic logic [31:0] sat_inc32(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_acc_o   <= '0;
      stat_ill_o   <= '0;
      stat_stall_o <= '0;
    end else begin
      if (enq_p0)                     stat_acc_o   <= sat_inc32(stat_acc_o);
      if (ill_p0)                     stat_ill_o   <= sat_inc16(stat_ill_o);
      if (pipe_vld_o && !pipe_rdy_i)  stat_stall_o <= sat_inc32(stat_stall_o);
    end
  end
`endif

endmodule
